// File: rtl/jk_pkg.sv
// Shared types and constants for the JK bank driver.
package jk_pkg;

  // Driver FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSettle
  } state_e;

  // Excitation codes, packed as {J, K}.
  localparam logic [1:0] ExcHold   = 2'b00;
  localparam logic [1:0] ExcReset  = 2'b01;
  localparam logic [1:0] ExcSet    = 2'b10;
  localparam logic [1:0] ExcToggle = 2'b11;

  // Wide enough for the largest supported retry budget (7).
  localparam int unsigned RetryW = 3;

endpackage

// File: rtl/jk_bank_driver_if.sv
// Request/completion handshake between a controller and the JK bank driver.
interface jk_bank_driver_if #(
  parameter int unsigned W = 4
);

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_target;
  logic         req_toggle;
  logic         done;
  logic         error;

  // Controller side: issues requests, observes completion.
  modport master (
    output req_valid,
    output req_target,
    output req_toggle,
    input  req_ready,
    input  done,
    input  error
  );

  // Driver side: accepts requests, reports completion.
  modport slave (
    input  req_valid,
    input  req_target,
    input  req_toggle,
    output req_ready,
    output done,
    output error
  );

endinterface

// File: rtl/jk_excite.sv
// Per-bit J/K excitation from the current Q (s) toward the target (t).
module jk_excite
  import jk_pkg::*;
(
  input  logic s,
  input  logic t,
  input  logic toggle,
  output logic j,
  output logic k
);

  logic [1:0] exc;

  // Toggle mode flips any differing bit; otherwise set or reset it explicitly.
  always_comb begin
    exc = ExcHold;
    if (s != t) begin
      if (toggle) begin
        exc = ExcToggle;
      end else if (t) begin
        exc = ExcSet;
      end else begin
        exc = ExcReset;
      end
    end
    {j, k} = exc;
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a JK flip-flop bank toward a requested word, verifying and retrying.
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int unsigned W         = 4,
  parameter int unsigned MAX_RETRY = 2,
  parameter bit          FAST_PC   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  jk_bank_driver_if.slave  bus,
  input  logic [W-1:0]     q_fb,
  output logic [W-1:0]     J,
  output logic [W-1:0]     K,
  output logic             Preset_n,
  output logic             Clear_n
);

  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  state_e            state_q;
  logic [W-1:0]      tgt_q;
  logic              tog_q;
  logic [RetryW-1:0] retry_q;
  logic [W-1:0]      j_q, k_q;
  logic              preset_n_q, clear_n_q;
  logic              done_q, error_q;

  // Target/mode feeding the excitation: live request in IDLE, latched copy on retry.
  logic [W-1:0] exc_t;
  logic         exc_tog;
  logic [W-1:0] exc_j, exc_k;
  logic [W-1:0] drv_j, drv_k;
  logic         drv_preset_n, drv_clear_n;
  logic         fast_set, fast_clr;

  // Select the target used to build the next DRIVE cycle.
  always_comb begin
    exc_t   = tgt_q;
    exc_tog = tog_q;
    if (state_q == StIdle) begin
      exc_t   = bus.req_target;
      exc_tog = bus.req_toggle;
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_excite
    jk_excite u_excite (
      .s      (q_fb[i]),
      .t      (exc_t[i]),
      .toggle (exc_tog),
      .j      (exc_j[i]),
      .k      (exc_k[i])
    );
  end

  // DRIVE-cycle outputs; uniform targets may use the bank-wide preset/clear instead.
  always_comb begin
    fast_set     = FAST_PC && (exc_t == {W{1'b1}});
    fast_clr     = FAST_PC && (exc_t == {W{1'b0}});
    drv_j        = exc_j;
    drv_k        = exc_k;
    drv_preset_n = 1'b1;
    drv_clear_n  = 1'b1;
    if (fast_set) begin
      drv_j        = '0;
      drv_k        = '0;
      drv_preset_n = 1'b0;
    end else if (fast_clr) begin
      drv_j        = '0;
      drv_k        = '0;
      drv_clear_n  = 1'b0;
    end
  end

  // Control FSM; all bank-facing and completion outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tgt_q      <= '0;
      tog_q      <= 1'b0;
      retry_q    <= '0;
      j_q        <= '0;
      k_q        <= '0;
      preset_n_q <= 1'b1;
      clear_n_q  <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      // Outputs are idle unless the branch below loads a DRIVE cycle or a completion.
      j_q        <= '0;
      k_q        <= '0;
      preset_n_q <= 1'b1;
      clear_n_q  <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            tgt_q      <= bus.req_target;
            tog_q      <= bus.req_toggle;
            retry_q    <= '0;
            j_q        <= drv_j;
            k_q        <= drv_k;
            preset_n_q <= drv_preset_n;
            clear_n_q  <= drv_clear_n;
            state_q    <= StDrive;
          end
        end
        StDrive: begin
          state_q <= StSettle;
        end
        StSettle: begin
          if (q_fb == tgt_q) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (retry_q < RetryMax) begin
            retry_q    <= retry_q + 1'b1;
            j_q        <= drv_j;
            k_q        <= drv_k;
            preset_n_q <= drv_preset_n;
            clear_n_q  <= drv_clear_n;
            state_q    <= StDrive;
          end else begin
            done_q  <= 1'b1;
            error_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign J             = j_q;
  assign K             = k_q;
  assign Preset_n      = preset_n_q;
  assign Clear_n       = clear_n_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.req_ready = (state_q == StIdle) && !rst;

endmodule
